ula_controle_8bits: RTL

- Sequencing front end that sits directly upstream of the 8-bit ULA and also consumes its outputs.
- Accepts one operation (A, B, opcode) per valid/ready handshake and drives the ULA operand and opcode inputs.
- Holds those inputs stable for an opcode-dependent number of cycles, so multi-cycle multiply and divide can finish.
- Then latches result and flags into an output register with its own valid/ready handshake.

---
 rtl/ula_pkg.sv | 49 ++++
 rtl/ula_reg_saida.sv | 33 +++
 rtl/ula_controle_8bits.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// ============================================================================
// Module   : ula_pkg
// Purpose  : Opcodes, FSM encoding, output-register record and latency select
//            shared by the ULA sequencing front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ula_pkg;

  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    EXECUTA   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  typedef struct packed {
    logic [7:0] resultado;
    logic       overflow;
    logic       zero;
    logic       carry_out;
    logic       erro;
  } saida_t;

  // Number of cycles the ULA inputs must stay stable for a given opcode.
  function automatic logic [3:0] latencia(input logic [2:0] op,
                                          input logic [3:0] lat_mult,
                                          input logic [3:0] lat_div);
    logic [3:0] w;
    case (op)
      OP_MULT: w = lat_mult;
      OP_DIV:  w = lat_div;
      default: w = 4'd1;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ula_reg_saida.sv
// ============================================================================
// Module   : ula_reg_saida
// Purpose  : 12-bit result/flag holding register with load enable and
//            asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_reg_saida
  import ula_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   carga_i,
  input  saida_t dado_i,
  output saida_t dado_o
);

  saida_t dado_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dado_q <= '0;
    end else if (carga_i) begin
      dado_q <= dado_i;
    end
  end

  assign dado_o = dado_q;

endmodule

`default_nettype wire

// File: rtl/ula_controle_8bits.sv
// ============================================================================
// Module   : ula_controle_8bits
// Purpose  : Valid/ready sequencer that drives the 8-bit ULA, holds its inputs
//            for an opcode-dependent latency and registers result and flags.
//            Optional accumulator operand source: define ULA_CTRL_ACC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_controle_8bits
  import ula_pkg::*;
#(
  parameter int unsigned LAT_MULT  = 8,
  parameter int unsigned LAT_DIV   = 10,
  parameter logic [2:0]  OP_OCIOSO = 3'b100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [2:0] in_op,
`ifdef ULA_CTRL_ACC_EN
  input  logic       in_usa_acc,
`endif
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_op,
  input  logic [7:0] ula_resultado,
  input  logic       ula_overflow,
  input  logic       ula_zero,
  input  logic       ula_carry_out,
  input  logic       ula_erro,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_resultado,
  output logic       out_overflow,
  output logic       out_zero,
  output logic       out_carry_out,
  output logic       out_erro
);

  localparam logic [3:0] c_lat_mult = LAT_MULT[3:0];
  localparam logic [3:0] c_lat_div  = LAT_DIV[3:0];

  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] ula_a_q, ula_a_d;
  logic [7:0] ula_b_q, ula_b_d;
  logic [2:0] ula_op_q, ula_op_d;
  logic       out_valid_q, out_valid_d;
  logic       captura;
  logic [7:0] operando_a;
  saida_t     captado;
  saida_t     saida_q;

`ifdef ULA_CTRL_ACC_EN
  logic [7:0] acc_q, acc_d;

  assign operando_a = in_usa_acc ? acc_q : in_a;
  assign acc_d      = captura ? ula_resultado : acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign operando_a = in_a;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q    <= OCIOSO;
      cnt_q       <= '0;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      ula_op_q    <= OP_OCIOSO;
      out_valid_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_op_q    <= ula_op_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_op_d    = ula_op_q;
    out_valid_d = out_valid_q;
    captura     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (in_valid) begin
          ula_a_d  = operando_a;
          ula_b_d  = in_b;
          ula_op_d = in_op;
          cnt_d    = latencia(in_op, c_lat_mult, c_lat_div) - 4'd1;
          estado_d = EXECUTA;
        end
      end
      EXECUTA: begin
        if (cnt_q == 4'd0) begin
          captura     = 1'b1;
          out_valid_d = 1'b1;
          estado_d    = RESULTADO;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESULTADO: begin
        // Operands stay put so the ULA outputs remain stable; only the
        // opcode is parked, keeping multiply/divide start deasserted.
        if (out_ready) begin
          out_valid_d = 1'b0;
          ula_op_d    = OP_OCIOSO;
          estado_d    = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign captado = '{resultado: ula_resultado, overflow: ula_overflow,
                     zero: ula_zero, carry_out: ula_carry_out, erro: ula_erro};

  ula_reg_saida u_reg_saida (
    .clk     (clk),
    .rst     (rst),
    .carga_i (captura),
    .dado_i  (captado),
    .dado_o  (saida_q)
  );

  assign in_ready      = (estado_q == OCIOSO);
  assign ula_a         = ula_a_q;
  assign ula_b         = ula_b_q;
  assign ula_op        = ula_op_q;
  assign out_valid     = out_valid_q;
  assign out_resultado = saida_q.resultado;
  assign out_overflow  = saida_q.overflow;
  assign out_zero      = saida_q.zero;
  assign out_carry_out = saida_q.carry_out;
  assign out_erro      = saida_q.erro;

endmodule

`default_nettype wire
